// File: rtl/game_countdown_timer_if.sv
// Control and status bundle between the game FSM (master) and the round countdown timer (slave).
// Status fields are registered inside the timer; the master may sample them at any time.
interface game_countdown_timer_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             pause;
   logic             load;
   logic [CNT_W-1:0] load_value;
   logic [CNT_W-1:0] remaining;
   logic [3:0]       bcd_tens;
   logic [3:0]       bcd_ones;
   logic             running;
   logic             warning;
   logic             finish;
   logic             expired;

   modport master (
      output start, pause, load, load_value,
      input  remaining, bcd_tens, bcd_ones, running, warning, finish, expired
   );

   modport slave (
      input  start, pause, load, load_value,
      output remaining, bcd_tens, bcd_ones, running, warning, finish, expired
   );
endinterface

// File: rtl/game_countdown_timer.sv
// Round countdown timer with prescaled ticks, pause/resume, reload-on-restart and a saturating BCD view.
// Controls take effect one edge after sampling; no backpressure, status outputs are registered or decoded from state.
module game_countdown_timer #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int TICK_HZ      = 1,
   parameter int CNT_W        = 16,
   parameter int DEFAULT_SECS = 30,
   parameter int WARN_SECS    = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   game_countdown_timer_if.slave tmr
);

   localparam int               DIV      = CLK_HZ / TICK_HZ;
   localparam int               PS_W     = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(DIV - 1);
   localparam logic [PS_W-1:0]  PS_ONE   = PS_W'(1);
   localparam logic [CNT_W-1:0] DEF_CNT  = CNT_W'(DEFAULT_SECS);
   localparam logic [CNT_W-1:0] WARN_CNT = CNT_W'(WARN_SECS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] BCD_MAX  = CNT_W'(99);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] reload_q, reload_d;
   logic [PS_W-1:0]  ps_q, ps_d;
   logic             expired_q, expired_d;
   logic [CNT_W-1:0] start_cnt;
   logic [6:0]       bcd_sat;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         rem_q     <= DEF_CNT;
         reload_q  <= DEF_CNT;
         ps_q      <= '0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         reload_q  <= reload_d;
         ps_q      <= ps_d;
         expired_q <= expired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      reload_d  = reload_q;
      ps_d      = ps_q;
      expired_d = 1'b0;
      // A restart from DONE counts down from the reload value, not the spent count.
      start_cnt = (state_q == DONE) ? reload_q : rem_q;

      if (tmr.load) begin
         rem_d    = tmr.load_value;
         reload_d = tmr.load_value;
         ps_d     = '0;
         state_d  = IDLE;
      end else if (tmr.start && (state_q == IDLE || state_q == DONE)) begin
         ps_d  = '0;
         rem_d = start_cnt;
         if (start_cnt != '0) begin
            state_d = RUN;
         end else begin
            state_d   = DONE;
            expired_d = 1'b1;
         end
      end else begin
         case (state_q)
            RUN: begin
               if (ps_q == PS_LAST) begin
                  ps_d = '0;
                  if (rem_q <= CNT_ONE) begin
                     rem_d     = '0;
                     state_d   = DONE;
                     expired_d = 1'b1;
                  end else begin
                     rem_d = rem_q - CNT_ONE;
                  end
               end else begin
                  ps_d = ps_q + PS_ONE;
               end
               // The tick of the pausing cycle still lands; expiry wins over pause.
               if (tmr.pause && state_d != DONE) begin
                  state_d = PAUSED;
               end
            end
            PAUSED: begin
               if (!tmr.pause) begin
                  state_d = RUN;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bcd_sat = (rem_q >= BCD_MAX) ? 7'd99 : rem_q[6:0];

   assign tmr.remaining = rem_q;
   assign tmr.bcd_tens  = 4'(bcd_sat / 7'd10);
   assign tmr.bcd_ones  = 4'(bcd_sat % 7'd10);
   assign tmr.running   = (state_q == RUN);
   assign tmr.finish    = (state_q == DONE);
   assign tmr.expired   = expired_q;
   assign tmr.warning   = (state_q == RUN || state_q == PAUSED) &&
                          (rem_q != '0) && (rem_q <= WARN_CNT);

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer at DIV = 10; stimulus queues expected snapshots and
// expiry cycles, a negedge monitor pops and compares them against the DUT.
module tb_game_countdown_timer;

   typedef struct packed {
      int          cyc;
      logic [15:0] rem;
      logic [3:0]  tens;
      logic [3:0]  ones;
      logic        run;
      logic        warn;
      logic        fin;
   } snap_t;

   logic  clock;
   logic  reset;
   int    cyc;
   int    total;
   int    bad;
   snap_t snap_q[$];
   string name_q[$];
   int    exp_q[$];
   snap_t e;
   string nm;
   int    ec;
   int    s, s2, s3, s4, z, p, rc, b;

   game_countdown_timer_if #(.CNT_W(16)) tif();

   game_countdown_timer #(
      .CLK_HZ      (10),
      .TICK_HZ     (1),
      .CNT_W       (16),
      .DEFAULT_SECS(30),
      .WARN_SECS   (5)
   ) dut (
      .clock(clock),
      .reset(reset),
      .tmr  (tif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic exp_at(input int at, input string n, input logic [15:0] r,
                         input logic [3:0] t, input logic [3:0] o,
                         input logic ru, input logic w, input logic f);
      snap_t x;
      x.cyc  = at;
      x.rem  = r;
      x.tens = t;
      x.ones = o;
      x.run  = ru;
      x.warn = w;
      x.fin  = f;
      snap_q.push_back(x);
      name_q.push_back(n);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   // Monitor: compares every snapshot due this cycle and every expired pulse.
   always @(negedge clock) begin
      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
         e  = snap_q.pop_front();
         nm = name_q.pop_front();
         total++;
         if (e.cyc != cyc) begin
            bad++;
            $display("FAIL %s: missed at cycle %0d, now cycle %0d", nm, e.cyc, cyc);
         end else if ({tif.remaining, tif.bcd_tens, tif.bcd_ones, tif.running, tif.warning, tif.finish}
                      !== {e.rem, e.tens, e.ones, e.run, e.warn, e.fin}) begin
            bad++;
            $display("FAIL %s @%0d: got rem=%0d bcd=%0d%0d run=%b warn=%b fin=%b, want rem=%0d bcd=%0d%0d run=%b warn=%b fin=%b",
                     nm, cyc, tif.remaining, tif.bcd_tens, tif.bcd_ones, tif.running, tif.warning, tif.finish,
                     e.rem, e.tens, e.ones, e.run, e.warn, e.fin);
         end
      end
      if (tif.expired === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL expired: unexpected pulse at cycle %0d, want none", cyc);
         end else begin
            ec = exp_q.pop_front();
            if (ec != cyc) begin
               bad++;
               $display("FAIL expired: pulse at cycle %0d, want cycle %0d", cyc, ec);
            end
         end
      end
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
         ec = exp_q.pop_front();
         total++;
         bad++;
         $display("FAIL expired: no pulse by cycle %0d, want cycle %0d", cyc, ec);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      tif.start      = 1'b0;
      tif.pause      = 1'b0;
      tif.load       = 1'b0;
      tif.load_value = '0;

      // Reset state
      step(1);
      exp_at(cyc + 1, "reset_state", 30, 3, 0, 0, 0, 0);
      step(2);
      reset = 1'b1;
      step(1);

      // Default 30-tick run
      s = cyc + 1;
      tif.start = 1'b1;
      exp_at(s,       "run_start", 30, 3, 0, 1, 0, 0);
      exp_at(s + 10,  "run_first_dec", 29, 2, 9, 1, 0, 0);
      exp_at(s + 249, "run_pre_warn", 6, 0, 6, 1, 0, 0);
      exp_at(s + 250, "run_warn5", 5, 0, 5, 1, 1, 0);
      exp_at(s + 299, "run_warn1", 1, 0, 1, 1, 1, 0);
      exp_at(s + 300, "run_done", 0, 0, 0, 0, 0, 1);
      exp_q.push_back(s + 300);
      step(1);
      tif.start = 1'b0;
      wait_until(s + 301);

      // Restart from DONE, then pause and resume
      s2 = cyc + 1;
      tif.start = 1'b1;
      exp_at(s2,      "restart", 30, 3, 0, 1, 0, 0);
      exp_at(s2 + 25, "pre_pause", 28, 2, 8, 1, 0, 0);
      step(1);
      tif.start = 1'b0;
      wait_until(s2 + 25);
      tif.pause = 1'b1;
      exp_at(s2 + 26, "paused", 28, 2, 8, 0, 0, 0);
      exp_at(s2 + 65, "paused_held", 28, 2, 8, 0, 0, 0);
      wait_until(s2 + 65);
      tif.pause = 1'b0;
      exp_at(s2 + 69, "resume_no_tick", 28, 2, 8, 1, 0, 0);
      exp_at(s2 + 70, "resume_tick", 27, 2, 7, 1, 0, 0);

      // Load while running, run short count, restart from DONE
      wait_until(s2 + 75);
      tif.load       = 1'b1;
      tif.load_value = 16'd3;
      exp_at(cyc + 1, "load_mid_run", 3, 0, 3, 0, 0, 0);
      step(1);
      tif.load = 1'b0;
      step(2);
      s3 = cyc + 1;
      tif.start = 1'b1;
      exp_at(s3,      "short_start", 3, 0, 3, 1, 1, 0);
      exp_at(s3 + 10, "short_dec", 2, 0, 2, 1, 1, 0);
      exp_at(s3 + 29, "short_last", 1, 0, 1, 1, 1, 0);
      exp_at(s3 + 30, "short_done", 0, 0, 0, 0, 0, 1);
      exp_q.push_back(s3 + 30);
      step(1);
      tif.start = 1'b0;
      wait_until(s3 + 32);
      s4 = cyc + 1;
      tif.start = 1'b1;
      exp_at(s4,      "reload_start", 3, 0, 3, 1, 1, 0);
      exp_at(s4 + 10, "reload_dec", 2, 0, 2, 1, 1, 0);
      exp_at(s4 + 30, "reload_done", 0, 0, 0, 0, 0, 1);
      exp_q.push_back(s4 + 30);
      step(1);
      tif.start = 1'b0;
      wait_until(s4 + 32);

      // Zero load then start
      tif.load       = 1'b1;
      tif.load_value = 16'd0;
      z = cyc + 1;
      exp_at(z, "zero_load", 0, 0, 0, 0, 0, 0);
      step(1);
      tif.load  = 1'b0;
      tif.start = 1'b1;
      exp_at(z + 1, "zero_start", 0, 0, 0, 0, 0, 1);
      exp_q.push_back(z + 1);
      step(1);
      tif.start = 1'b0;
      exp_at(z + 3, "zero_hold", 0, 0, 0, 0, 0, 1);
      wait_until(z + 3);

      // Priority: load over start, then start over pause
      tif.load       = 1'b1;
      tif.load_value = 16'd7;
      tif.start      = 1'b1;
      p = cyc + 1;
      exp_at(p, "load_over_start", 7, 0, 7, 0, 0, 0);
      step(1);
      tif.load  = 1'b0;
      tif.start = 1'b1;
      tif.pause = 1'b1;
      exp_at(p + 1, "start_over_pause", 7, 0, 7, 1, 0, 0);
      step(1);
      tif.start = 1'b0;
      exp_at(p + 2, "then_paused", 7, 0, 7, 0, 0, 0);
      step(1);
      tif.pause = 1'b0;
      exp_at(p + 4, "pre_reset_run", 7, 0, 7, 1, 0, 0);
      wait_until(p + 4);

      // Asynchronous reset between edges
      @(posedge clock);
      #2;
      reset = 1'b0;
      rc = cyc;
      exp_at(rc, "async_reset", 30, 3, 0, 0, 0, 0);
      step(2);
      exp_at(rc + 2, "reset_held", 30, 3, 0, 0, 0, 0);
      step(1);
      reset = 1'b1;
      exp_at(rc + 5, "post_reset_idle", 30, 3, 0, 0, 0, 0);
      wait_until(rc + 5);

      // BCD saturation and digit split
      tif.load       = 1'b1;
      tif.load_value = 16'd150;
      b = cyc + 1;
      exp_at(b, "bcd_150", 150, 9, 9, 0, 0, 0);
      step(1);
      tif.load_value = 16'd99;
      exp_at(b + 1, "bcd_99", 99, 9, 9, 0, 0, 0);
      step(1);
      tif.load_value = 16'd98;
      exp_at(b + 2, "bcd_98", 98, 9, 8, 0, 0, 0);
      step(1);
      tif.load_value = 16'd7;
      exp_at(b + 3, "bcd_7", 7, 0, 7, 0, 0, 0);
      step(1);
      tif.load = 1'b0;
      exp_at(b + 5, "bcd_7_hold", 7, 0, 7, 0, 0, 0);
      wait_until(b + 7);

      total++;
      if (snap_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_snapshots: %0d pending, want 0", snap_q.size());
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_expiries: %0d pending, want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
